dump_vram_m: RTL

Test-infrastructure block that sweeps the GPU VRAM from address 0 to `VRAM_SIZE-1` through its read port and streams every byte out on a valid/ready interface, tagged with its address. It is the read-side counterpart to the VRAM fill engine and is used by benches and on-board self-test to dump or checksum VRAM contents. It handles a synchronous VRAM read latency and downstream backpressure without dropping or duplicating bytes.

---
 rtl/gpu_test_pkg.sv | 20 ++
 rtl/dump_vram_fifo_m.sv | 53 +++++
 rtl/dump_vram_m.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/gpu_test_pkg.sv
// Shared types for the VRAM dump engine: sweep states and FIFO entry layout.
// VRAM geometry mirrors the GPU parameters so the dump covers the whole array.
package gpu_test_pkg;

    localparam int unsigned VRAM_SIZE       = 2304;
    localparam int unsigned VRAM_ADDR_WIDTH = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } dump_state_t;

    typedef struct packed {
        logic [7:0]                 data;
        logic [VRAM_ADDR_WIDTH-1:0] addr;
        logic                       last;
    } dump_entry_t;

endpackage

// File: rtl/dump_vram_fifo_m.sv
// Synchronous power-of-two FIFO of dump entries with an occupancy count.
// Storage is cleared on reset so the head reads as zero while idle.
module dump_vram_fifo_m
    import gpu_test_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  dump_entry_t                i_data,
    input  logic                       i_pop,
    output dump_entry_t                o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    dump_entry_t      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    // Issue credit accounting must make a push into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(i_push && !i_pop && (r_count == CNT_W'(DEPTH))));

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/dump_vram_m.sv
// Sweeps VRAM 0..VRAM_SIZE-1 through the read port and streams each byte with
// its address over valid/ready, keeping a running 16-bit checksum.
module dump_vram_m
    import gpu_test_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic [VRAM_ADDR_WIDTH-1:0] vram_address,
    output logic                       vram_read_enable,
    input  logic [7:0]                 vram_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_data,
    output logic [VRAM_ADDR_WIDTH-1:0] out_address,
    output logic                       out_last,
    output logic                       in_progress,
    output logic                       done,
    output logic [15:0]                checksum
);
    localparam int unsigned   AW        = VRAM_ADDR_WIDTH;
    localparam int unsigned   CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(VRAM_SIZE - 1);

    dump_state_t             r_state;
    logic [AW-1:0]           r_vram_address;
    logic [AW-1:0]           r_next_addr;
    logic                    r_read_enable;
    logic [CNT_W-1:0]        r_inflight;
    logic                    r_in_progress;
    logic                    r_done;
    logic [15:0]             r_checksum;
    logic [READ_LATENCY-1:0] r_pipe_valid;
    logic [AW-1:0]           r_pipe_addr [READ_LATENCY];

    logic [CNT_W-1:0] w_fifo_count;
    logic             w_fifo_empty;
    dump_entry_t      w_head;
    dump_entry_t      w_push_entry;
    logic             w_push;
    logic             w_pop;
    logic             w_room;
    logic             w_issue;

    // Credit check uses registered counts only; a same-cycle pop is not credited.
    assign w_room  = (32'(w_fifo_count) + 32'(r_inflight)) < FIFO_DEPTH;
    assign w_issue = ((r_state == IDLE) && start) || ((r_state == ISSUE) && w_room);
    assign w_pop   = !w_fifo_empty && out_ready;
    assign w_push  = r_pipe_valid[READ_LATENCY-1];

    assign w_push_entry.data = vram_data;
    assign w_push_entry.addr = r_pipe_addr[READ_LATENCY-1];
    assign w_push_entry.last = (r_pipe_addr[READ_LATENCY-1] == LAST_ADDR);

    // Read-tracking pipe: aligns each strobe's address with its returning data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_valid <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe_addr[i] <= '0;
            end
        end else begin
            r_pipe_valid[0] <= r_read_enable;
            r_pipe_addr[0]  <= r_vram_address;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe_valid[i] <= r_pipe_valid[i-1];
                r_pipe_addr[i]  <= r_pipe_addr[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_vram_address <= '0;
            r_next_addr    <= '0;
            r_read_enable  <= 1'b0;
            r_inflight     <= '0;
            r_in_progress  <= 1'b0;
            r_done         <= 1'b0;
            r_checksum     <= '0;
        end else begin
            r_read_enable <= 1'b0;
            r_done        <= 1'b0;
            r_inflight    <= r_inflight + CNT_W'(w_issue) - CNT_W'(w_push);
            if (w_pop) begin
                r_checksum <= r_checksum + 16'(w_head.data);
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state        <= ISSUE;
                        r_in_progress  <= 1'b1;
                        r_checksum     <= '0;
                        r_vram_address <= '0;
                        r_next_addr    <= AW'(1);
                        r_read_enable  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (w_room) begin
                        r_vram_address <= r_next_addr;
                        r_next_addr    <= r_next_addr + AW'(1);
                        r_read_enable  <= 1'b1;
                        if (r_next_addr == LAST_ADDR) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Entries leave in address order, so popping the last one empties everything.
                    if (w_pop && w_head.last) begin
                        r_state       <= IDLE;
                        r_in_progress <= 1'b0;
                        r_done        <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    dump_vram_fifo_m #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty)
    );

    assign vram_address     = r_vram_address;
    assign vram_read_enable = r_read_enable;
    assign out_valid        = !w_fifo_empty;
    assign out_data         = w_head.data;
    assign out_address      = w_head.addr;
    assign out_last         = w_head.last;
    assign in_progress      = r_in_progress;
    assign done             = r_done;
    assign checksum         = r_checksum;

endmodule
